// File: rtl/sfifo_ctrl_pkg.sv
// rtl/sfifo_ctrl_pkg.sv - shared helpers for the synchronous FIFO controller
package sfifo_ctrl_pkg;

    function automatic int fifo_depth(input int depth_bits);
        return 1 << depth_bits;
    endfunction

endpackage

// File: rtl/sfifo_ctrl_if.sv
// rtl/sfifo_ctrl_if.sv - write/read request and status bundle of the synchronous FIFO
interface sfifo_ctrl_if #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 3
);
    logic                  wr;
    logic [WIDTH-1:0]      din;
    logic                  rd;
    logic [WIDTH-1:0]      dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [DEPTH_BITS:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, din, rd,
        input  dout, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr, din, rd,
        output dout, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_data.sv
// rtl/fifo_data.sv - FIFO storage array, unreset, with combinational show-ahead read port
module fifo_data #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic [DEPTH_BITS-1:0] rptr,
    input  logic [DEPTH_BITS-1:0] wptr,
    input  logic                  wr,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout
);
    logic [WIDTH-1:0] mem [2**DEPTH_BITS];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= din;
        end
    end

    assign dout = mem[rptr];
endmodule

// File: rtl/sfifo_ctrl.sv
// rtl/sfifo_ctrl.sv - synchronous FIFO controller: pointers, occupancy count and status flags
module sfifo_ctrl
    import sfifo_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 3,
    parameter int AF_LEVEL   = fifo_depth(DEPTH_BITS) - 2
) (
    input  logic         clk,
    input  logic         rst,
    sfifo_ctrl_if.slave  bus
);
    localparam int                  DEPTH   = fifo_depth(DEPTH_BITS);
    localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] AF_C    = (DEPTH_BITS+1)'(AF_LEVEL);

    logic [DEPTH_BITS-1:0] wptr_q, wptr_d;
    logic [DEPTH_BITS-1:0] rptr_q, rptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok, rd_ok;

    // Requests coinciding with rst are discarded: they neither move state nor set sticky flags.
    always_comb begin
        rd_ok         = bus.rd && !empty_q && !rst;
        wr_ok         = bus.wr && (!full_q || rd_ok) && !rst;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d       = count_q + {{DEPTH_BITS{1'b0}}, wr_ok} - {{DEPTH_BITS{1'b0}}, rd_ok};
        full_d        = (count_d == DEPTH_C);
        empty_d       = (count_d == '0);
        almost_full_d = (count_d >= AF_C);
        if (bus.wr && full_q && !rd_ok && !rst) begin
            overflow_d = 1'b1;
        end
        if (bus.rd && empty_q && !rst) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= (AF_LEVEL == 0);
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    fifo_data #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo_data (
        .clk  (clk),
        .rptr (rptr_q),
        .wptr (wptr_q),
        .wr   (wr_ok),
        .din  (bus.din),
        .dout (bus.dout)
    );

    assign bus.count       = count_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.almost_full = almost_full_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_sfifo_ctrl.sv
// tb/tb_sfifo_ctrl.sv - directed and randomized checks of sfifo_ctrl against a queue model
module tb_sfifo_ctrl;
    localparam int W     = 16;
    localparam int DB    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] mq[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    sfifo_ctrl_if #(.WIDTH(W), .DEPTH_BITS(DB)) bus ();

    sfifo_ctrl #(.WIDTH(W), .DEPTH_BITS(DB), .AF_LEVEL(AF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, W'(bus.count), W'(mq.size()));
        chk({tag, ".full"}, W'(bus.full), W'(mq.size() == DEPTH));
        chk({tag, ".empty"}, W'(bus.empty), W'(mq.size() == 0));
        chk({tag, ".almost_full"}, W'(bus.almost_full), W'(mq.size() >= AF));
        chk({tag, ".overflow"}, W'(bus.overflow), W'(m_ovf));
        chk({tag, ".underflow"}, W'(bus.underflow), W'(m_unf));
        if (mq.size() != 0) begin
            chk({tag, ".dout"}, bus.dout, mq[0]);
        end
    endtask

    // One clock: drive, check the show-ahead head being popped, advance model, check results.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [W-1:0] d, input logic rs);
        bit rok, wok;
        logic [W-1:0] head;
        bus.wr = w;
        bus.rd = r;
        bus.din = d;
        rst = rs;
        rok = r && (mq.size() != 0) && !rs;
        wok = w && ((mq.size() != DEPTH) || rok) && !rs;
        if (rok) begin
            chk({tag, ".pop"}, bus.dout, mq[0]);
        end
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && (mq.size() == DEPTH) && !rok) m_ovf = 1'b1;
            if (r && (mq.size() == 0)) m_unf = 1'b1;
            if (rok) head = mq.pop_front();
            if (wok) mq.push_back(d);
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.din = '0;

        step("reset", 1'b1, 1'b1, 16'hDEAD, 1'b1);
        chk("reset.almost_full0", W'(bus.almost_full), 16'h0);

        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, W'(i), 1'b0);
        chk("fill.full_const", W'(bus.full), 16'h1);

        step("ovf_write", 1'b1, 1'b0, 16'h00AA, 1'b0);
        chk("ovf_write.overflow_const", W'(bus.overflow), 16'h1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain.order", bus.dout, W'(i));
            step("drain", 1'b0, 1'b1, 16'h0, 1'b0);
        end

        step("empty_rw", 1'b1, 1'b1, 16'h1234, 1'b0);
        chk("empty_rw.dout_const", bus.dout, 16'h1234);

        step("rst2", 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 1; i <= 8; i++) step("fill2", 1'b1, 1'b0, W'(i), 1'b0);
        step("full_rw", 1'b1, 1'b1, 16'h5555, 1'b0);
        chk("full_rw.dout_const", bus.dout, 16'h0002);
        for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b1, 16'h0, 1'b0);

        step("rst3", 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) step("prime", 1'b1, 1'b0, W'(16'h00F0 + i), 1'b0);
        for (int i = 0; i < 20; i++) step("steady", 1'b1, 1'b1, W'(16'h0100 + i), 1'b0);
        chk("steady.count_const", W'(bus.count), 16'h3);
        for (int i = 0; i < 3; i++) step("drain3", 1'b0, 1'b1, 16'h0, 1'b0);

        for (int i = 0; i < 5; i++) step("fill5", 1'b1, 1'b0, W'(16'h0A00 + i), 1'b0);
        step("rst_wr", 1'b1, 1'b0, 16'h7777, 1'b1);
        chk("rst_wr.empty_const", W'(bus.empty), 16'h1);
        step("post_rst", 1'b1, 1'b0, 16'h0BEE, 1'b0);
        chk("post_rst.dout_const", bus.dout, 16'h0BEE);

        for (int i = 0; i < 400; i++) begin
            step("random", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                 W'($urandom), ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sfifo_ctrl.md
SFIFO_CTRL -- requirements
Module: sfifo_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width in bits.
REQ-002 The block SHALL have parameter DEPTH_BITS, default 3, meaning log2 of FIFO depth; DEPTH = 2**DEPTH_BITS.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the count at or above which almost_full asserts.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 wr  input  1  write request; din is captured when accepted.
REQ-007 din  input  WIDTH  write data.
REQ-008 rd  input  1  read request; pops the head entry when accepted.
REQ-009 dout  output  WIDTH  head-of-FIFO data, show-ahead, valid whenever empty=0.
REQ-010 full  output  1  registered; asserted when count == DEPTH.
REQ-011 empty  output  1  registered; asserted when count == 0.
REQ-012 almost_full  output  1  registered; asserted when count >= AF_LEVEL.
REQ-013 count  output  DEPTH_BITS+1  registered number of stored entries, 0..DEPTH.
REQ-014 overflow  output  1  sticky; set on a write request while full and not simultaneously accepting a read.
REQ-015 underflow  output  1  sticky; set on a read request while empty.

Function
REQ-016 Write SHALL be accepted (wr_ok) when wr=1 and (full=0 or rd_ok=1).
REQ-017 Read SHALL be accepted (rd_ok) when rd=1 and empty=0.
REQ-018 On wr_ok the storage entry at wptr SHALL be written with din at the clock edge and wptr SHALL increment by 1 modulo DEPTH.
REQ-019 On rd_ok rptr SHALL increment by 1 modulo DEPTH at the clock edge; dout SHALL reflect the new head combinationally from rptr with zero added latency.
REQ-020 count SHALL update as count + wr_ok - rd_ok; it SHALL never exceed DEPTH or go below 0.
REQ-021 full, empty and almost_full SHALL be computed from the next count value and registered, so they are exact in the cycle after each edge.
REQ-022 Simultaneous rd and wr while empty: write accepted, read rejected, underflow set, count becomes 1, dout shows din the following cycle.
REQ-023 Simultaneous rd and wr while full: both accepted, count stays DEPTH, the popped head is returned on dout before the edge, the freed slot receives din.
REQ-024 Simultaneous accepted rd and wr at any other level: count unchanged, both pointers advance.
REQ-025 Pointer wrap-around from DEPTH-1 to 0 SHALL occur with no bubble and no flag glitch.
REQ-026 A rejected write SHALL leave storage, wptr and count unchanged; a rejected read SHALL leave rptr and count unchanged.
REQ-027 overflow and underflow SHALL remain set until rst.

Reset
REQ-028 On rst=1 at a clock edge: wptr=0, rptr=0, count=0, empty=1, full=0, almost_full=0 (unless AF_LEVEL=0, then 1), overflow=0, underflow=0.
REQ-029 rst SHALL take priority over wr and rd in the same cycle; a request coinciding with rst is discarded and sets no flag.
REQ-030 Storage contents SHALL NOT be reset; dout is don't-care while empty=1.
REQ-031 Reset mid-operation SHALL discard all stored entries; the first write after reset SHALL appear on dout one cycle later.

Structure
REQ-032 No shared package types are needed; DEPTH and AF_LEVEL SHALL be derived as local parameters from DEPTH_BITS.
REQ-033 Storage SHALL be a single instance of the existing fifo_data block (ports clk, rptr, wptr, wr, din, dout) with WIDTH and DEPTH_BITS passed through and wr driven by wr_ok.
REQ-034 All pointer, count and flag logic SHALL reside in sfifo_ctrl.

Verification (WIDTH=16, DEPTH_BITS=3, AF_LEVEL=6)
REQ-035 Reset, then write 0x0001..0x0008 on consecutive cycles -> full=1 and count=8 after the 8th edge, almost_full=1 from the 6th edge, overflow stays 0.
REQ-036 From full, write 0x00AA with rd=0 -> overflow=1, count=8, the following 8 reads return 0x0001..0x0008 in order.
REQ-037 From empty, rd=1 and wr=1 with din=0x1234 -> underflow=1, count=1, empty=0, dout=0x1234 next cycle.
REQ-038 From full, rd=1 and wr=1 with din=0x5555 for one cycle -> count=8, dout returns 0x0001 then 0x0002, 0x5555 emerges as 8th read.
REQ-039 Push/pop 20 words 0x0100..0x0113 at count=3 steady state -> in-order data across two wraps, count constant at 3, no flags set.
REQ-040 Assert rst at count=5 together with wr=1 -> count=0, empty=1, flags 0 next cycle; write 0x0BEE then dout=0x0BEE.
